nbcac_23b_word_packer: RTL and testbench

//  - Upstream feeder for the 23-bit-input NBCAC 33-bit encoder. Packs a byte stream into 23-bit data words.
//  - LSB-first bit packing. Holds each word stable on word_out while downstream pacing (out_ready) stalls.
//  - Supports a flush request that emits a final zero-padded partial word.
//  - Sits between the byte-stream source and the encoder; the encoder registers word_out every clock.

---
 rtl/nbcac_pkg.sv | 25 ++
 rtl/nbcac_bit_accumulator.sv | 89 ++++++++
 rtl/nbcac_23b_word_packer.sv | 144 ++++++++++++++
 tb/tb_nbcac_23b_word_packer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nbcac_pkg.sv
// -----------------------------------------------------------------------------
// nbcac_pkg
//   Constants and types shared by the NBCAC front-end blocks.
//   NBCAC_DATA_W : data width consumed by the 33-bit NBCAC encoder
//   NBCAC_CODE_W : width of the encoded codeword
//   pack_state_e : word packer control state (RUN accepts bytes, FLUSH drains)
//   pack_acc_w() : accumulator width able to hold a partial word plus one beat
// -----------------------------------------------------------------------------
package nbcac_pkg;

   localparam int NBCAC_DATA_W = 23;
   localparam int NBCAC_CODE_W = 33;

   typedef enum logic [0:0] {
      PK_RUN   = 1'b0,
      PK_FLUSH = 1'b1
   } pack_state_e;

   // A byte is only accepted while at most WORD_W-1 bits are held, so the
   // accumulator never needs more than WORD_W-1+IN_W bits.
   function automatic int pack_acc_w(input int in_w, input int word_w);
      return word_w + in_w - 1;
   endfunction

endpackage : nbcac_pkg

// File: rtl/nbcac_bit_accumulator.sv
// -----------------------------------------------------------------------------
// nbcac_bit_accumulator
//   LSB-first bit accumulator for the word packer. Holds the residual bits,
//   removes a word from the bottom when the output register can take one, and
//   inserts an accepted beat directly above the bits that remain.
// Ports
//   clock, rst_n : clock, asynchronous active-low reset
//   out_free     : output register can load a word this cycle
//   flush_mode   : packer is draining; a partial word may be emitted
//   push         : an input beat is accepted this cycle
//   in_data      : the beat being accepted (bit0 is packed first)
//   cnt          : number of valid bits currently held
//   word         : low WORD_W bits of the accumulator (upper unused bits are 0)
//   pop_full     : a complete word leaves the accumulator this cycle
//   pop_pad      : a zero-padded partial word leaves this cycle
//   pop          : either kind of pop
// -----------------------------------------------------------------------------
module nbcac_bit_accumulator
   import nbcac_pkg::*;
#(
   parameter  int IN_W   = 8,
   parameter  int WORD_W = NBCAC_DATA_W,
   localparam int ACC_W  = pack_acc_w(IN_W, WORD_W),
   localparam int CNT_W  = $clog2(ACC_W + 1)
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              out_free,
   input  logic              flush_mode,
   input  logic              push,
   input  logic [IN_W-1:0]   in_data,
   output logic [CNT_W-1:0]  cnt,
   output logic [WORD_W-1:0] word,
   output logic              pop_full,
   output logic              pop_pad,
   output logic              pop
);

   localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);
   localparam logic [CNT_W-1:0] IN_CNT   = CNT_W'(IN_W);

   logic [ACC_W-1:0] acc_q, acc_d, acc_popped;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_popped;

   // Bits above cnt_q are always zero, so a padded remnant is simply the low
   // word of the accumulator.
   always_comb begin
      pop_full = out_free && (cnt_q >= WORD_CNT);
      pop_pad  = out_free && flush_mode && (cnt_q != '0) && (cnt_q < WORD_CNT);
      pop      = pop_full || pop_pad;
   end

   // Pop first, then insert the new beat at the post-pop fill level; this is
   // what lets a byte be accepted in the same cycle a full word leaves.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      acc_popped = acc_q;
      cnt_popped = cnt_q;
      if (pop_full) begin
         acc_popped = acc_q >> WORD_W;
         cnt_popped = cnt_q - WORD_CNT;
      end else if (pop_pad) begin
         acc_popped = '0;
         cnt_popped = '0;
      end

      acc_d = acc_popped;
      cnt_d = cnt_popped;
      if (push) begin
         acc_d = acc_popped | (ACC_W'(in_data) << cnt_popped);
         cnt_d = cnt_popped + IN_CNT;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign word = acc_q[WORD_W-1:0];

endmodule : nbcac_bit_accumulator

// File: rtl/nbcac_23b_word_packer.sv
// -----------------------------------------------------------------------------
// nbcac_23b_word_packer
//   Packs a byte stream LSB-first into 23-bit words for the NBCAC encoder.
//   A word is held stable on word_out until out_ready consumes it. A flush
//   request drains all complete words and then a zero-padded remnant.
// Ports
//   clock, rst_n  : clock, asynchronous active-low reset
//   in_data       : input byte, bit0 packed first
//   in_valid      : input beat valid
//   in_ready      : beat accepted when in_valid && in_ready at a rising edge
//   flush_req     : one-cycle pulse requesting emission of residual bits
//   word_out      : packed word, stable while word_valid && !out_ready
//   word_valid    : word_out holds an unconsumed word
//   word_padded   : the held word is a zero-padded flush remnant
//   out_ready     : word consumed at an edge where word_valid && out_ready
//   flush_done    : one-cycle pulse when a flush completes
// -----------------------------------------------------------------------------
module nbcac_23b_word_packer
   import nbcac_pkg::*;
#(
   parameter int IN_W   = 8,
   parameter int WORD_W = NBCAC_DATA_W
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic [IN_W-1:0]   in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush_req,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   output logic              word_padded,
   input  logic              out_ready,
   output logic              flush_done
);

   localparam int ACC_W = pack_acc_w(IN_W, WORD_W);
   localparam int CNT_W = $clog2(ACC_W + 1);
   localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(WORD_W);

   pack_state_e       state_q, state_d;
   logic              flush_pend_q, flush_pend_d;
   logic              flush_done_q, flush_done_d;
   logic [WORD_W-1:0] word_out_q, word_out_d;
   logic              word_valid_q, word_valid_d;
   logic              word_padded_q, word_padded_d;

   logic [CNT_W-1:0]  cnt;
   logic [WORD_W-1:0] acc_word;
   logic              pop_full, pop_pad, pop;
   logic              out_free, push;

   // The output register is free if empty or being consumed on this edge.
   assign out_free = !word_valid_q || out_ready;

   // Room for a byte exists if at most WORD_W-1 bits are held, or a full word
   // leaves on this same edge. Gated by rst_n so it reads 0 during reset.
   assign in_ready = (state_q == PK_RUN) && ((cnt < WORD_CNT) || pop_full) && rst_n;
   assign push     = in_valid && in_ready;

   nbcac_bit_accumulator #(
      .IN_W   (IN_W),
      .WORD_W (WORD_W)
   ) u_acc (
      .clock      (clock),
      .rst_n      (rst_n),
      .out_free   (out_free),
      .flush_mode (state_q == PK_FLUSH),
      .push       (push),
      .in_data    (in_data),
      .cnt        (cnt),
      .word       (acc_word),
      .pop_full   (pop_full),
      .pop_pad    (pop_pad),
      .pop        (pop)
   );

   // Flush control. A request is latched in RUN and takes effect one edge
   // later, so a byte accepted in that cycle still joins the flush. Further
   // requests are dropped until the flush completes.
   always_comb begin
      state_d      = state_q;
      flush_pend_d = flush_pend_q;
      flush_done_d = 1'b0;
      unique case (state_q)
         PK_RUN: begin
            if (flush_pend_q) begin
               state_d = PK_FLUSH;
            end else if (flush_req) begin
               flush_pend_d = 1'b1;
            end
         end
         PK_FLUSH: begin
            // With nothing left in the accumulator no further pop can occur.
            if (cnt == '0) begin
               state_d      = PK_RUN;
               flush_pend_d = 1'b0;
               flush_done_d = 1'b1;
            end
         end
         default: state_d = PK_RUN;
      endcase
   end

   // Output register: load on pop, otherwise clear valid when consumed and
   // hold everything while stalled.
   always_comb begin
      word_out_d    = word_out_q;
      word_valid_d  = word_valid_q;
      word_padded_d = word_padded_q;
      if (pop) begin
         word_out_d    = acc_word;
         word_valid_d  = 1'b1;
         word_padded_d = pop_pad;
      end else if (word_valid_q && out_ready) begin
         word_valid_d  = 1'b0;
         word_padded_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= PK_RUN;
         flush_pend_q  <= 1'b0;
         flush_done_q  <= 1'b0;
         word_out_q    <= '0;
         word_valid_q  <= 1'b0;
         word_padded_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         flush_pend_q  <= flush_pend_d;
         flush_done_q  <= flush_done_d;
         word_out_q    <= word_out_d;
         word_valid_q  <= word_valid_d;
         word_padded_q <= word_padded_d;
      end
   end

   assign word_out    = word_out_q;
   assign word_valid  = word_valid_q;
   assign word_padded = word_padded_q;
   assign flush_done  = flush_done_q;

endmodule : nbcac_23b_word_packer

// File: tb/tb_nbcac_23b_word_packer.sv
// -----------------------------------------------------------------------------
// tb_nbcac_23b_word_packer
//   Scoreboard bench. Accepted bytes feed a bit-queue reference packer that
//   pushes expected words; a negedge monitor pops and compares every word the
//   DUT hands over, and checks hold stability and flush behaviour.
// -----------------------------------------------------------------------------
module tb_nbcac_23b_word_packer;

   typedef struct packed {
      logic [22:0] word;
      logic        padded;
   } exp_t;

   logic        clock;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        flush_req;
   logic [22:0] word_out;
   logic        word_valid;
   logic        word_padded;
   logic        out_ready;
   logic        flush_done;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   bit   bitq[$];
   exp_t exp_q[$];
   bit   m_pend     = 0;
   bit   m_in_flush = 0;

   // monitor bookkeeping
   int          n_consumed    = 0;
   int          n_padded      = 0;
   int          n_flush_done  = 0;
   int          flush_rdy_err = 0;
   int          stall_cnt     = 0;
   logic [22:0] last_word     = '0;
   bit          hold_q        = 0;
   logic [22:0] hold_word     = '0;
   logic        hold_pad      = 0;

   nbcac_23b_word_packer dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .flush_req   (flush_req),
      .word_out    (word_out),
      .word_valid  (word_valid),
      .word_padded (word_padded),
      .out_ready   (out_ready),
      .flush_done  (flush_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor + reference model. Sampled at negedge, so every value seen here
   // is what the next rising edge acts on.
   always @(negedge clock) begin
      if (!rst_n) begin
         bitq.delete();
         exp_q.delete();
         m_pend        = 0;
         m_in_flush    = 0;
         hold_q        = 0;
         flush_rdy_err = 0;
      end else begin
         if (hold_q) begin
            check("hold valid", word_valid, 1);
            check("hold word", word_out, hold_word);
            check("hold padded", word_padded, hold_pad);
         end
         hold_q    = word_valid && !out_ready;
         hold_word = word_out;
         hold_pad  = word_padded;

         if (word_valid && out_ready) begin
            n_consumed++;
            if (word_padded) n_padded++;
            last_word = word_out;
            if (exp_q.size() == 0) begin
               check("unexpected word", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("word", word_out, e.word);
               check("padded", word_padded, e.padded);
            end
         end

         if (flush_done) begin
            n_flush_done++;
            check("flush_done while flushing", m_in_flush, 1);
            check("in_ready low in flush", flush_rdy_err, 0);
            flush_rdy_err = 0;
            m_in_flush    = 0;
         end else if (m_in_flush && in_ready) begin
            flush_rdy_err++;
         end

         // reference packer: plain bit queue, words cut every 23 bits
         if (in_valid && in_ready) begin
            for (int i = 0; i < 8; i++) bitq.push_back(in_data[i]);
            while (bitq.size() >= 23) begin
               logic [22:0] w;
               for (int i = 0; i < 23; i++) w[i] = bitq.pop_front();
               exp_q.push_back(exp_t'{word: w, padded: 1'b0});
            end
         end
         if (m_pend) begin
            if (bitq.size() > 0) begin
               logic [22:0] w;
               int n;
               w = '0;
               n = bitq.size();
               for (int i = 0; i < n; i++) w[i] = bitq.pop_front();
               exp_q.push_back(exp_t'{word: w, padded: 1'b1});
            end
            m_pend     = 0;
            m_in_flush = 1;
         end else if (!m_in_flush && flush_req) begin
            m_pend = 1;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int w;
      w        = 0;
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clock);
      while (!in_ready && w < 100) begin
         stall_cnt++;
         @(negedge clock);
         w++;
      end
      if (!in_ready) check("send timeout", 0, 1);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int w;
      w         = 0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || m_pend || m_in_flush) && w < 300) begin
         tick();
         w++;
      end
      check("drain", exp_q.size(), 0);
      repeat (2) tick();
   endtask

   task automatic do_flush(input bit with_byte, input logic [7:0] b);
      int f0, w;
      f0        = n_flush_done;
      w         = 0;
      out_ready = 1'b1;
      flush_req = 1'b1;
      if (with_byte) begin
         in_valid = 1'b1;
         in_data  = b;
      end
      tick();
      flush_req = 1'b0;
      in_valid  = 1'b0;
      while (n_flush_done == f0 && w < 200) begin
         tick();
         w++;
      end
      check("flush_done seen", n_flush_done - f0, 1);
      repeat (2) tick();
      check("flush_done one cycle", flush_done, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int c0, p0, acc_n, stall;
      logic [7:0] b;

      rst_n = 1'b0; in_data = '0; in_valid = 1'b0; flush_req = 1'b0; out_ready = 1'b0;
      #1;
      check("rst word_valid", word_valid, 0);
      check("rst word_out", word_out, 0);
      check("rst word_padded", word_padded, 0);
      check("rst flush_done", flush_done, 0);
      check("rst in_ready", in_ready, 0);
      repeat (2) @(posedge clock);
      #1 rst_n = 1'b1;
      tick();
      check("post-rst in_ready", in_ready, 1);
      check("post-rst cnt", dut.u_acc.cnt, 0);

      // three bytes -> one word 0x030201, one residual bit
      out_ready = 1'b1;
      c0 = n_consumed;
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      wait_idle();
      check("t2 words", n_consumed - c0, 1);
      check("t2 word value", last_word, 23'h030201);
      check("t2 residual", dut.u_acc.cnt, 1);
      do_flush(0, 8'h00);
      wait_idle();
      check("t2 flushed cnt", dut.u_acc.cnt, 0);

      // 23 x 0xFF back-to-back -> 8 full words, no stall
      c0 = n_consumed;
      stall_cnt = 0;
      for (int i = 0; i < 23; i++) send_byte(8'hFF);
      check("t3 no stall", stall_cnt, 0);
      wait_idle();
      check("t3 words", n_consumed - c0, 8);
      check("t3 last word", last_word, 23'h7FFFFF);
      check("t3 cnt", dut.u_acc.cnt, 0);

      // backpressure: 6 bytes fit (one word held, 25 bits queued)
      out_ready = 1'b0;
      acc_n = 0;
      stall = 0;
      for (int c = 0; c < 20 && stall < 3; c++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h11 * (acc_n + 1));
         @(negedge clock);
         if (in_ready) begin acc_n++; stall = 0; end
         else stall++;
         tick();
      end
      in_valid = 1'b0;
      check("t4 accepted", acc_n, 6);
      check("t4 in_ready low", in_ready, 0);
      check("t4 word held", word_valid, 1);
      c0 = n_consumed;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t4 one consumed", n_consumed - c0, 1);
      check("t4 next word", word_valid, 1);
      repeat (3) tick();
      wait_idle();
      check("t4 total", n_consumed - c0, 2);
      do_flush(0, 8'h00);
      wait_idle();

      // flush of a single byte
      p0 = n_padded;
      send_byte(8'hA5);
      do_flush(0, 8'h00);
      wait_idle();
      check("t5 padded words", n_padded - p0, 1);
      check("t5 word", last_word, 23'h0000A5);
      check("t5 cnt", dut.u_acc.cnt, 0);

      // flush with nothing held: no word
      c0 = n_consumed;
      do_flush(0, 8'h00);
      wait_idle();
      check("t6a no word", n_consumed - c0, 0);

      // 20 bytes leave 22 bits; flush together with the byte bringing cnt to 30
      for (int i = 0; i < 20; i++) send_byte(8'($urandom));
      wait_idle();
      check("t6b cnt 22", dut.u_acc.cnt, 22);
      c0 = n_consumed;
      p0 = n_padded;
      b  = 8'($urandom);
      do_flush(1, b);
      wait_idle();
      check("t6b words", n_consumed - c0, 2);
      check("t6b padded", n_padded - p0, 1);
      check("t6b remnant", last_word, 23'(b >> 1));

      // randomized traffic
      for (int c = 0; c < 2500; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         flush_req = ($urandom_range(0, 40) == 0);
         tick();
      end
      in_valid  = 1'b0;
      flush_req = 1'b0;
      wait_idle();
      do_flush(0, 8'h00);
      wait_idle();
      check("rand cnt", dut.u_acc.cnt, 0);

      // reset mid-stream with a held word
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_byte(8'h5A);
      check("t1 word held", word_valid, 1);
      @(posedge clock);
      #2 rst_n = 1'b0;
      #1;
      check("t1 word_valid", word_valid, 0);
      check("t1 word_out", word_out, 0);
      check("t1 word_padded", word_padded, 0);
      check("t1 flush_done", flush_done, 0);
      check("t1 in_ready", in_ready, 0);
      repeat (2) @(posedge clock);
      #1 rst_n = 1'b1;
      tick();
      check("t1 in_ready after", in_ready, 1);
      check("t1 cnt after", dut.u_acc.cnt, 0);
      c0 = n_consumed;
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      wait_idle();
      check("t1 words after", n_consumed - c0, 1);
      check("t1 word after", last_word, 23'h030201);

      check("end queue empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_nbcac_23b_word_packer
